// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and constants for the RV32I control sequencer: FSM states, opcodes and ALU codes.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef enum logic [5:0] {
    AluNop   = 6'd0,
    AluAdd   = 6'd1,
    AluSub   = 6'd2,
    AluSll   = 6'd3,
    AluSlt   = 6'd4,
    AluSltu  = 6'd5,
    AluXor   = 6'd6,
    AluSrl   = 6'd7,
    AluSra   = 6'd8,
    AluOr    = 6'd9,
    AluAnd   = 6'd10,
    AluCmpEq = 6'd11,
    AluCmpNe = 6'd12,
    AluCmpGe = 6'd13,
    AluCmpLt = 6'd14
  } alu_op_e;

  // funct7[5] selects SUB only for register-register ops; SRA/SRL for both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic f7b5,
                                         input logic is_reg);
    case (funct3)
      3'b000:  return (is_reg && f7b5) ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return f7b5 ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction (I/S/B/J/U formats) from the instruction register.
module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j,
  output logic [31:0] imm_u
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I sequencer: owns the PC, fetches over ready/valid, decodes and drives strobes.
module control_sequencer
  import rv32i_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        beq,
  input  logic        bneq,
  input  logic        bgeq,
  input  logic        blt,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg_num,
  output alu_op_e     alu_cntrl,
  output logic        beq_cntrl,
  output logic        bneq_cntrl,
  output logic        bgeq_cntrl,
  output logic        blt_cntrl,
  output logic        jump,
  output logic        lui_cntrl,
  output logic        lb,
  output logic        sw,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic [31:0] imm_val,
  output logic [3:0]  shamt,
  output logic [31:0] imm_val_lui,
  output logic [31:0] imm_val_jump,
  output logic [31:0] return_address,
  output logic        illegal_instr
);

  state_e      state_q;
  logic        armed_q;
  logic        taken_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_op, is_opimm, is_load, is_store, is_branch, is_lui, is_jal, dec_legal;
  alu_op_e     dec_alu;
  logic [31:0] dec_imm;
  logic [31:0] next_pc;

  assign imem_addr = pc_q;

  imm_gen u_imm_gen (
    .instr(ir_q),
    .imm_i(imm_i),
    .imm_s(imm_s),
    .imm_b(imm_b),
    .imm_j(imm_j),
    .imm_u(imm_u)
  );

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_op     = (opcode == OpcOp);
  assign is_opimm  = (opcode == OpcOpImm);
  assign is_load   = (opcode == OpcLoad);
  assign is_store  = (opcode == OpcStore);
  assign is_branch = (opcode == OpcBranch);
  assign is_lui    = (opcode == OpcLui);
  assign is_jal    = (opcode == OpcJal);
  assign dec_legal = is_op | is_opimm | is_load | is_store | is_branch | is_lui | is_jal;

  always_comb begin
    dec_alu = AluNop;
    dec_imm = imm_i;
    if (is_op) begin
      dec_alu = alu_decode(funct3, ir_q[30], 1'b1);
    end else if (is_opimm) begin
      dec_alu = alu_decode(funct3, ir_q[30], 1'b0);
    end else if (is_load) begin
      dec_alu = AluAdd;
    end else if (is_store) begin
      dec_alu = AluAdd;
      dec_imm = imm_s;
    end else if (is_branch) begin
      dec_imm = imm_b;
      case (funct3)
        3'b000:  dec_alu = AluCmpEq;
        3'b001:  dec_alu = AluCmpNe;
        3'b101:  dec_alu = AluCmpGe;
        3'b100:  dec_alu = AluCmpLt;
        default: dec_alu = AluNop;
      endcase
    end
  end

  // imm_val still holds the B-immediate during WB for a taken branch.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (is_jal) begin
      next_pc = pc_q + imm_val_jump;
    end else if (taken_q) begin
      next_pc = pc_q + imm_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      armed_q        <= 1'b0;
      taken_q        <= 1'b0;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      imem_req       <= 1'b0;
      read_reg_num1  <= '0;
      read_reg_num2  <= '0;
      write_reg_num  <= '0;
      alu_cntrl      <= AluNop;
      beq_cntrl      <= 1'b0;
      bneq_cntrl     <= 1'b0;
      bgeq_cntrl     <= 1'b0;
      blt_cntrl      <= 1'b0;
      jump           <= 1'b0;
      lui_cntrl      <= 1'b0;
      lb             <= 1'b0;
      sw             <= 1'b0;
      mem_to_reg     <= 1'b0;
      reg_dst        <= 1'b0;
      imm_val        <= '0;
      shamt          <= '0;
      imm_val_lui    <= '0;
      imm_val_jump   <= '0;
      return_address <= '0;
      illegal_instr  <= 1'b0;
    end else begin
      // Per-state controls default low; each state re-asserts what it owns.
      imem_req   <= 1'b0;
      alu_cntrl  <= AluNop;
      beq_cntrl  <= 1'b0;
      bneq_cntrl <= 1'b0;
      bgeq_cntrl <= 1'b0;
      blt_cntrl  <= 1'b0;
      jump       <= 1'b0;
      lui_cntrl  <= 1'b0;
      lb         <= 1'b0;
      sw         <= 1'b0;
      mem_to_reg <= 1'b0;
      unique case (state_q)
        StIdle: begin
          armed_q <= 1'b1;
          if (armed_q) begin
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            state_q <= StDecode;
          end else begin
            imem_req <= 1'b1;
          end
        end
        StDecode: begin
          if (!dec_legal) begin
            illegal_instr <= 1'b1;
            reg_dst       <= 1'b0;
            state_q       <= StHalt;
          end else begin
            read_reg_num1  <= ir_q[19:15];
            read_reg_num2  <= ir_q[24:20];
            write_reg_num  <= ir_q[11:7];
            imm_val        <= dec_imm;
            shamt          <= ir_q[23:20];
            imm_val_lui    <= imm_u;
            imm_val_jump   <= imm_j;
            return_address <= pc_q + 32'd4;
            reg_dst        <= is_op | is_opimm | is_load | is_lui | is_jal;
            alu_cntrl      <= dec_alu;
            beq_cntrl      <= is_branch && (funct3 == 3'b000);
            bneq_cntrl     <= is_branch && (funct3 == 3'b001);
            bgeq_cntrl     <= is_branch && (funct3 == 3'b101);
            blt_cntrl      <= is_branch && (funct3 == 3'b100);
            taken_q        <= 1'b0;
            state_q        <= StExec;
          end
        end
        StExec: begin
          taken_q <= is_branch & (beq | bneq | bgeq | blt);
          if (is_load || is_store) begin
            sw         <= is_store;
            lb         <= is_load;
            mem_to_reg <= is_load;
            state_q    <= StMem;
          end else begin
            lui_cntrl <= is_lui;
            jump      <= is_jal;
            state_q   <= StWb;
          end
        end
        StMem: begin
          lb         <= is_load;
          mem_to_reg <= is_load;
          state_q    <= StWb;
        end
        StWb: begin
          pc_q     <= next_pc;
          imem_req <= 1'b1;
          state_q  <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer against a behavioural instruction model.
module tb_control_sequencer;
  import rv32i_ctrl_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        beq = 1'b0, bneq = 1'b0, bgeq = 1'b0, blt = 1'b0;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg_num;
  alu_op_e     alu_cntrl;
  logic        beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl;
  logic        jump, lui_cntrl, lb, sw, mem_to_reg, reg_dst;
  logic [31:0] imm_val, imm_val_lui, imm_val_jump, return_address;
  logic [3:0]  shamt;
  logic        illegal_instr;

  int checks = 0;
  int failures = 0;
  logic [31:0] pc_m;

  always #5 clk = ~clk;

  control_sequencer #(.RESET_PC(ResetPc)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .beq(beq), .bneq(bneq), .bgeq(bgeq), .blt(blt),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg_num(write_reg_num), .alu_cntrl(alu_cntrl),
    .beq_cntrl(beq_cntrl), .bneq_cntrl(bneq_cntrl), .bgeq_cntrl(bgeq_cntrl),
    .blt_cntrl(blt_cntrl), .jump(jump), .lui_cntrl(lui_cntrl), .lb(lb), .sw(sw),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .imm_val(imm_val), .shamt(shamt),
    .imm_val_lui(imm_val_lui), .imm_val_jump(imm_val_jump),
    .return_address(return_address), .illegal_instr(illegal_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_flags();
    {beq, bneq, bgeq, blt} = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_regs"}, {read_reg_num1, read_reg_num2, write_reg_num}, 0);
    check({tag, "_alu"}, alu_cntrl, 0);
    check({tag, "_brsel"}, {beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl}, 0);
    check({tag, "_strobes"}, {jump, lui_cntrl, lb, sw, mem_to_reg, reg_dst, illegal_instr}, 0);
    check({tag, "_imm"}, imm_val, 0);
    check({tag, "_shamt"}, shamt, 0);
    check({tag, "_imm_lui"}, imm_val_lui, 0);
    check({tag, "_imm_jump"}, imm_val_jump, 0);
    check({tag, "_ret"}, return_address, 0);
  endtask

  // Asserts reset in the middle of a cycle, then releases it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    imem_ready = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    reset = 1'b1;
    pc_m = ResetPc;
    @(negedge clk);
    check("idle_req", imem_req, 0);
    check("idle_addr", imem_addr, ResetPc);
    @(negedge clk);
    check("first_req", imem_req, 1);
  endtask

  function automatic int ref_alu(input logic [31:0] instr);
    int base;
    logic [2:0] f3;
    f3 = instr[14:12];
    case (f3)
      3'd0: base = 1;  3'd1: base = 3;  3'd2: base = 4;  3'd3: base = 5;
      3'd4: base = 6;  3'd5: base = 7;  3'd6: base = 9;  default: base = 10;
    endcase
    case (instr[6:0])
      7'b0110011: return base + (((f3 == 0 || f3 == 5) && instr[30]) ? 1 : 0);
      7'b0010011: return base + ((f3 == 5 && instr[30]) ? 1 : 0);
      7'b0000011, 7'b0100011: return 1;
      7'b1100011: begin
        case (f3)
          3'd0: return 11;
          3'd1: return 12;
          3'd5: return 13;
          3'd4: return 14;
          default: return 0;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] instr, input logic [3:0] flags, input int stalls);
    logic [6:0] opc;
    logic [2:0] f3;
    bit op, opi, ld, st, br, lui, jal, legal, taken;
    int si, hi, imm_i, imm_s, imm_b, imm_j;
    logic [31:0] next_pc;
    opc = instr[6:0];
    f3  = instr[14:12];
    op  = (opc == 7'b0110011);  opi = (opc == 7'b0010011);
    ld  = (opc == 7'b0000011);  st  = (opc == 7'b0100011);
    br  = (opc == 7'b1100011);  lui = (opc == 7'b0110111);
    jal = (opc == 7'b1101111);
    legal = op | opi | ld | st | br | lui | jal;
    si = $signed(instr);
    imm_i = si >>> 20;
    hi = si >>> 25;
    imm_s = hi * 32 + int'(instr[11:7]);
    hi = si >>> 31;
    imm_b = hi * 4096 + int'(instr[7]) * 2048 + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
    imm_j = hi * 1048576 + int'(instr[19:12]) * 4096 + int'(instr[20]) * 2048
          + int'(instr[30:21]) * 2;
    taken = br && (flags != 4'd0);
    next_pc = jal ? pc_m + 32'(imm_j) : (taken ? pc_m + 32'(imm_b) : pc_m + 32'd4);

    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, pc_m);
    for (int s = 0; s < stalls; s++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      junk_flags();
      @(negedge clk);
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, pc_m);
    end
    imem_ready = 1'b1;
    imem_rdata = instr;
    junk_flags();
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("dec_req", imem_req, 0);
    check("dec_alu", alu_cntrl, 0);
    check("dec_strobes", {sw, lb, jump, lui_cntrl}, 0);
    junk_flags();
    @(negedge clk);
    if (!legal) begin
      for (int c = 0; c < 5; c++) begin
        check("halt_req", imem_req, 0);
        check("halt_illegal", illegal_instr, 1);
        check("halt_strobes", {sw, lb, jump, lui_cntrl, mem_to_reg, reg_dst}, 0);
        check("halt_alu", alu_cntrl, 0);
        junk_flags();
        @(negedge clk);
      end
      return;
    end
    check("ex_rs1", read_reg_num1, instr[19:15]);
    check("ex_rs2", read_reg_num2, instr[24:20]);
    check("ex_rd", write_reg_num, instr[11:7]);
    check("ex_alu", alu_cntrl, ref_alu(instr));
    check("ex_beqc", beq_cntrl, br && f3 == 3'd0);
    check("ex_bneqc", bneq_cntrl, br && f3 == 3'd1);
    check("ex_bgeqc", bgeq_cntrl, br && f3 == 3'd5);
    check("ex_bltc", blt_cntrl, br && f3 == 3'd4);
    if (opi || ld) check("ex_imm_i", imm_val, 32'(imm_i));
    if (st) check("ex_imm_s", imm_val, 32'(imm_s));
    if (br) check("ex_imm_b", imm_val, 32'(imm_b));
    check("ex_shamt", shamt, instr[23:20]);
    check("ex_imm_lui", imm_val_lui, {instr[31:12], 12'h000});
    check("ex_imm_jump", imm_val_jump, 32'(imm_j));
    check("ex_ret", return_address, pc_m + 32'd4);
    check("ex_req", imem_req, 0);
    check("ex_strobes", {sw, lb, jump, lui_cntrl}, 0);
    {beq, bneq, bgeq, blt} = flags;
    @(negedge clk);
    junk_flags();
    if (ld || st) begin
      check("mem_sw", sw, st);
      check("mem_lb", lb, ld);
      check("mem_m2r", mem_to_reg, ld);
      check("mem_alu", alu_cntrl, 0);
      check("mem_req", imem_req, 0);
      @(negedge clk);
      junk_flags();
    end
    check("wb_jump", jump, jal);
    check("wb_lui", lui_cntrl, lui);
    check("wb_lb", lb, ld);
    check("wb_sw", sw, 0);
    check("wb_brsel", {beq_cntrl, bneq_cntrl, bgeq_cntrl, blt_cntrl}, 0);
    check("wb_req", imem_req, 0);
    check("wb_addr", imem_addr, pc_m);
    @(negedge clk);
    pc_m = next_pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0] f3;
    logic [1:0] b;
    int k;
    r = $urandom;
    k = $urandom_range(0, 6);
    f3 = r[14:12];
    b = r[13:12];
    case (k)
      0: begin
        r[31:25] = ((f3 == 0 || f3 == 5) && r[30]) ? 7'h20 : 7'h00;
        r[6:0] = 7'b0110011;
      end
      1: begin
        if (f3 == 1 || f3 == 5) r[31:25] = r[30] ? 7'h20 : 7'h00;
        r[6:0] = 7'b0010011;
      end
      2: begin r[14:12] = 3'b010; r[6:0] = 7'b0000011; end
      3: begin r[14:12] = 3'b010; r[6:0] = 7'b0100011; end
      4: begin
        r[14:12] = (b == 0) ? 3'd0 : (b == 1) ? 3'd1 : (b == 2) ? 3'd4 : 3'd5;
        r[6:0] = 7'b1100011;
      end
      5: r[6:0] = 7'b0110111;
      default: r[6:0] = 7'b1101111;
    endcase
    return r;
  endfunction

  initial begin
    do_reset();
    run_instr(32'h002081B3, 4'h0, 0);  // add x3,x1,x2 at 0
    run_instr(32'h00500093, 4'h0, 1);  // addi x1,x0,5 at 4
    run_instr(32'h00208863, 4'h8, 0);  // beq +16 at 8, taken -> 24
    check("beq_taken_pc", imem_addr, 32'd24);
    run_instr(32'hFF1FF0EF, 4'h0, 0);  // jal -16 at 24 -> 8
    run_instr(32'h00208863, 4'h0, 2);  // beq +16 at 8, not taken -> 12
    check("beq_not_taken_pc", imem_addr, 32'd12);
    run_instr(32'h123452B7, 4'h0, 0);  // lui x5,0x12345
    run_instr(32'h0040A183, 4'h0, 0);  // lw x3,4(x1)
    for (int i = 0; i < 40; i++) begin
      run_instr(rand_instr(), 4'($urandom), $urandom_range(0, 2));
    end
    @(negedge clk);
    do_reset();                        // abandons a FETCH stalled on imem_ready=0
    run_instr(32'hFE20AE23, 4'h0, 0);  // sw x2,-4(x1) at 0
    run_instr(32'hFF9FF0EF, 4'h0, 0);  // jal -8 at 4 -> FFFF_FFFC
    check("jal_wrap_pc", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h00500093, 4'hF, 0);  // addi at FFFF_FFFC wraps to 0
    check("pc_wrap", imem_addr, 32'h0);
    run_instr(32'h0000007F, 4'h0, 1);  // illegal opcode -> HALT
    do_reset();
    check("illegal_cleared", illegal_instr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
